fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word-aligned reads to instruction memory over a valid/ready request channel.
- Accepts in-order responses of arbitrary latency and buffers them in a small FIFO.
- Presents {instruction, PC} pairs to decode with a valid/ready handshake.
- Supports redirect (branch/jump) with a flush of buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
FIFO_DEPTH, 2, instruction buffer entries; legal 2..8; also the cap on outstanding requests plus buffered entries

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  request byte address, always [1:0]=00
imem_resp_valid  in  1  response word valid, one per accepted request, in order, ≥1 cycle after acceptance
imem_resp_data  in  32  instruction word
ins  out  32  instruction to decode
ins_pc  out  32  PC of ins
ins_valid  out  1  ins/ins_pc valid
ins_ready  in  1  decode consumes entry
redirect_valid  in  1  redirect request, single-cycle pulse
redirect_pc  in  32  new PC; bits [1:0] forced to 00

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. Ports are clk and rst.

Reset values:
- pc=RESET_PC, resp_pc=RESET_PC, fifo count=0, outstanding=0, discard=0.
- ins_valid=0, ins=32'h0000_0013 (NOP) whenever the FIFO is empty, ins_pc=0 when empty, imem_req_valid=0 during the reset cycle.
- Reset mid-operation drops all buffered entries. Responses arriving after reset for pre-reset requests are NOT tracked; the memory must be reset in the same cycle.

Requests:
- imem_req_valid = !rst && !redirect_valid && (outstanding + count < FIFO_DEPTH). imem_req_addr = pc.
- Request fires on valid&&ready: pc <= pc+4 (wraps at 32'hFFFF_FFFC to 0), outstanding++.
- While imem_req_ready=0, imem_req_valid and addr remain stable unless a redirect occurs.

Responses:
- If discard>0: response dropped, discard--, outstanding--.
- Else: push {imem_resp_data, resp_pc}, resp_pc += 4, outstanding--.
- The credit rule guarantees no push to a full FIFO.
- Simultaneous request-fire and response: outstanding unchanged.

Output:
- ins, ins_pc and ins_valid are driven from the FIFO head.
- Pop on ins_valid && ins_ready.
- Push and pop in the same cycle are both honoured, including when full (pop frees a slot, push writes it).
- Latency: response at cycle N -> ins_valid at N+1. Back-to-back responses with ins_ready=1 give 1 instr/cycle.

Redirect (redirect_valid=1):
- FIFO cleared; pc and resp_pc <= {redirect_pc[31:2],2'b00}.
- discard <= outstanding after this cycle's request/response accounting; no request issued this cycle.
- A response arriving in the redirect cycle belongs to the old stream and is dropped.
- ins_valid=0 the cycle after redirect.
- A pop coincident with redirect has no further effect.
- Back-to-back redirects: the last one wins; discard keeps counting all old in-flight requests.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty and a non-discarded response arrives with no redirect, ins/ins_pc/ins_valid present it combinationally the same cycle.
  - If ins_ready=1, the entry is consumed without being written.
  - Otherwise it is written to the FIFO as normal.
  - Latency 0.
- Undefined: all outputs come from FIFO registers, latency 1.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle memory returning addr-based words, ins_ready=1 -> addresses 0,4,8,... issued; ins_pc sequence 0,4,8 with matching data; no bubbles after start.
- ins_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0. Raise ins_ready -> entries PC 0,4 drain in order, fetching resumes at 8.
- imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and imem_req_addr stable at 0x0; no pc advance.
- Two requests in flight (0x10, 0x14), redirect_pc=0x200 -> both responses dropped; next ins_pc=0x200; discard returns to 0.
- Redirect coinciding with a response and a pop -> FIFO empty next cycle, response dropped, next request addr 0x200.
- redirect_pc=0x203 -> fetch at 0x200. pc at 0xFFFF_FFFC -> next request addr 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, in-order response buffering and redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    logic [31:0]      pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] out_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      ins_mem [FIFO_DEPTH];
    logic [31:0]      pc_mem  [FIFO_DEPTH];

    logic req_fire;
    logic resp_keep;
    logic resp_drop;
    logic fifo_empty;
    logic bypass;
    logic push;
    logic pop;

    // Credit covers both in-flight requests and buffered words, so a response never hits a full FIFO.
    assign imem_req_valid = !rst && !redirect_valid && ((outstanding + count) < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && !redirect_valid && (discard == '0);
    assign resp_drop      = imem_resp_valid && !redirect_valid && (discard != '0);
    assign fifo_empty     = (count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = !rst && fifo_empty && resp_keep;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        ins_valid = !rst && (!fifo_empty || bypass);
        ins       = NOP;
        ins_pc    = 32'h0000_0000;
        if (!fifo_empty) begin
            ins    = ins_mem[rd_ptr];
            ins_pc = pc_mem[rd_ptr];
        end else if (bypass) begin
            ins    = imem_resp_data;
            ins_pc = resp_pc;
        end
    end

    // A bypassed word consumed by decode in the same cycle never occupies a slot.
    assign pop      = !redirect_valid && !fifo_empty && ins_ready;
    assign push     = resp_keep && !(bypass && ins_ready);
    assign out_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= word_align(RESET_PC);
            resp_pc     <= word_align(RESET_PC);
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                pc      <= word_align(redirect_pc);
                resp_pc <= word_align(redirect_pc);
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                discard <= out_next;
            end else begin
                if (req_fire)  pc      <= pc + 32'd4;
                if (resp_keep) resp_pc <= resp_pc + 32'd4;
                if (resp_drop) discard <= discard - CNT_W'(1);
                if (push)      wr_ptr  <= ptr_inc(wr_ptr);
                if (pop)       rd_ptr  <= ptr_inc(rd_ptr);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr] <= imem_resp_data;
            pc_mem[wr_ptr]  <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model plus an in-order decode scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ins_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          lat = 1;
    int          ncyc = 0;
    int          fire_cnt = 0;
    logic        fire_c = 1'b0;
    logic        resp_c = 1'b0;
    logic [31:0] addr_c = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ins(input logic [31:0] pc, input logic [31:0] word);
        exp_pc_q.push_back(pc);
        exp_ins_q.push_back(word);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        ins_ready = 1'b0;
        tick(2);
        exp_pc_q.delete();
        exp_ins_q.delete();
        exp_addr_q.delete();
        rst = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] a);
        redirect_pc = a;
        redirect_valid = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int i;
        for (i = 0; i < max && (exp_pc_q.size() > 0 || exp_addr_q.size() > 0); i++) tick(1);
        checks++;
        if (exp_pc_q.size() > 0 || exp_addr_q.size() > 0) begin
            errors++;
            $display("FAIL %s: %0d entries and %0d requests still expected after %0d cycles, required 0",
                     name, exp_pc_q.size(), exp_addr_q.size(), max);
        end
    endtask

    // Handshakes are captured just before the rising edge so the memory model sees settled values.
    always @(negedge clk) begin
        #4;
        fire_c = imem_req_valid && imem_req_ready;
        addr_c = imem_req_addr;
        resp_c = imem_resp_valid;
    end

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            fire_cnt = 0;
        end else begin
            if (resp_c && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (fire_c) begin
                fire_cnt++;
                pend_addr.push_back(addr_c);
                pend_due.push_back(ncyc + lat - 1);
                if (exp_addr_q.size() > 0) check32("req_addr", addr_c, exp_addr_q.pop_front());
            end
        end
        if (pend_addr.size() > 0 && pend_due[0] <= ncyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr[0] ^ 32'hA5A5_0000;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && ins_valid && ins_ready && exp_pc_q.size() > 0) begin
            check32("ins_pc", ins_pc, exp_pc_q.pop_front());
            check32("ins", ins, exp_ins_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        ins_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        lat = 1;
        tick(2);
        #1;
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_ins_valid", ins_valid, 1'b0);
        check32("rst_ins_nop", ins, 32'h0000_0013);
        check32("rst_ins_pc", ins_pc, 32'h0000_0000);
        tick(1);
        rst = 1'b0;

        // Memory stalled: request held at the reset PC.
        repeat (5) begin
            #1;
            check1("stall_req_valid", imem_req_valid, 1'b1);
            check32("stall_req_addr", imem_req_addr, 32'h0000_0000);
            tick(1);
        end

        // Streaming from PC 0 with a 1-cycle memory.
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            expect_ins(32'(i * 4), 32'hA5A5_0000 | 32'(i * 4));
        end
        imem_req_ready = 1'b1;
        ins_ready = 1'b1;
        wait_drain("stream_drain", 200);

        // Decode blocked: credit stops fetch after two requests.
        do_reset();
        lat = 1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        imem_req_ready = 1'b1;
        tick(6);
        #1;
        check32("full_fire_cnt", 32'(fire_cnt), 32'd2);
        check1("full_req_valid", imem_req_valid, 1'b0);
        check1("full_ins_valid", ins_valid, 1'b1);
        check32("full_head_pc", ins_pc, 32'h0000_0000);
        check32("full_head_ins", ins, 32'hA5A5_0000);
        expect_ins(32'h0, 32'hA5A5_0000);
        expect_ins(32'h4, 32'hA5A5_0004);
        expect_ins(32'h8, 32'hA5A5_0008);
        expect_ins(32'hC, 32'hA5A5_000C);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        ins_ready = 1'b1;
        wait_drain("full_drain", 100);

        // Redirect with two slow fetches in flight.
        do_reset();
        lat = 4;
        ins_ready = 1'b1;
        pulse_redirect(32'h0000_0010);
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h14);
        imem_req_ready = 1'b1;
        tick(2);
        imem_req_ready = 1'b0;
        pulse_redirect(32'h0000_0200);
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h204);
        expect_ins(32'h200, 32'hA5A5_0200);
        expect_ins(32'h204, 32'hA5A5_0204);
        imem_req_ready = 1'b1;
        wait_drain("inflight_redirect", 100);

        // Redirect coinciding with a response and a pop; unaligned target.
        do_reset();
        lat = 2;
        imem_req_ready = 1'b1;
        found = 1'b0;
        repeat (20) begin
            #1;
            if (imem_resp_valid && ins_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check1("coinc_setup_found", found, 1'b1);
        redirect_pc = 32'h0000_0203;
        redirect_valid = 1'b1;
        ins_ready = 1'b1;
        exp_addr_q.push_back(32'h200);
        tick(1);
        redirect_valid = 1'b0;
        #1;
        check1("coinc_ins_valid", ins_valid, 1'b0);
        expect_ins(32'h200, 32'hA5A5_0200);
        expect_ins(32'h204, 32'hA5A5_0204);
        wait_drain("coinc_drain", 100);

        // Back-to-back redirects, last lands at the top of the address space.
        do_reset();
        lat = 1;
        ins_ready = 1'b1;
        redirect_pc = 32'h0000_0300;
        redirect_valid = 1'b1;
        tick(1);
        redirect_pc = 32'hFFFF_FFFE;
        tick(1);
        redirect_valid = 1'b0;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        exp_addr_q.push_back(32'h0000_0004);
        expect_ins(32'hFFFF_FFFC, 32'h5A5A_FFFC);
        expect_ins(32'h0000_0000, 32'hA5A5_0000);
        expect_ins(32'h0000_0004, 32'hA5A5_0004);
        imem_req_ready = 1'b1;
        wait_drain("wrap_drain", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
